trace_buffer: RTL

- Circular on-chip trace store placed directly downstream of the data packer.
- Captures each packed N-wide vector (packer valid_out/vector_out) while tracing is active.
- Keeps the most recent TB_SIZE vectors, overwriting the oldest when full.
- After tracing stops, drains oldest-first to the host readout path over a valid/ready handshake.

---
 rtl/trace_buffer.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/trace_buffer.sv
// Circular trace store behind the data packer: captures packed vectors while
// tracing, keeps the newest TB_SIZE of them, then drains oldest-first to the host.
module trace_buffer #(
    parameter int N          = 8,
    parameter int DATA_WIDTH = 32,
    parameter int TB_SIZE    = 8,
    parameter int DROP_WIDTH = 16
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               tracing,
    input  logic                               valid_in,
    input  logic [N-1:0][DATA_WIDTH-1:0]       vector_in,
    input  logic                               drain_req,
    input  logic                               out_ready,
    output logic                               out_valid,
    output logic [N-1:0][DATA_WIDTH-1:0]       vector_out,
    output logic                               out_last,
    output logic [$clog2(TB_SIZE):0]           occupancy,
    output logic                               wrapped,
    output logic [DROP_WIDTH-1:0]              drop_count,
    output logic                               busy,
    output logic                               dbg_state_o
);

    localparam int PTR_W = $clog2(TB_SIZE);
    localparam int OCC_W = PTR_W + 1;
    localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(TB_SIZE);
    localparam logic [OCC_W-1:0] OCC_ONE  = OCC_W'(1);
    localparam logic [OCC_W-1:0] OCC_TWO  = OCC_W'(2);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [DROP_WIDTH-1:0] DROP_MAX = {DROP_WIDTH{1'b1}};

    typedef enum logic {
        S_CAPTURE = 1'b0,
        S_DRAIN   = 1'b1
    } state_t;

    logic [N-1:0][DATA_WIDTH-1:0] mem [TB_SIZE];

    state_t                       state_q, state_d;
    logic [PTR_W-1:0]             wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]             rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0]             occ_q, occ_d;
    logic                         wrapped_q, wrapped_d;
    logic [DROP_WIDTH-1:0]        drop_q, drop_d;
    logic                         out_valid_q, out_valid_d;
    logic                         out_last_q, out_last_d;
    logic [N-1:0][DATA_WIDTH-1:0] vec_q, vec_d;

    logic             write_en;
    logic             handshake;
    logic [PTR_W-1:0] rd_ptr_inc;

    // Output handshake: a beat transfers on any rising edge where out_valid and
    // out_ready are both high; until then vector_out/out_last are held stable.
    assign write_en   = (state_q == S_CAPTURE) && valid_in && tracing;
    assign handshake  = out_valid_q && out_ready;
    assign rd_ptr_inc = rd_ptr_q + PTR_ONE;

    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        occ_d       = occ_q;
        wrapped_d   = wrapped_q;
        drop_d      = drop_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        vec_d       = vec_q;

        case (state_q)
            S_CAPTURE: begin
                if (write_en) begin
                    wr_ptr_d = wr_ptr_q + PTR_ONE;
                    if (occ_q == OCC_FULL) begin
                        // Full: the oldest entry is overwritten, so the read side advances with it.
                        rd_ptr_d  = rd_ptr_inc;
                        wrapped_d = 1'b1;
                    end else begin
                        occ_d = occ_q + OCC_ONE;
                    end
                end else if (drain_req && !tracing && (occ_q != '0)) begin
                    state_d     = S_DRAIN;
                    out_valid_d = 1'b1;
                    out_last_d  = (occ_q == OCC_ONE);
                    vec_d       = mem[rd_ptr_q];
                end
            end

            S_DRAIN: begin
                if (valid_in && tracing && (drop_q != DROP_MAX)) begin
                    drop_d = drop_q + DROP_WIDTH'(1);
                end
                if (handshake) begin
                    rd_ptr_d = rd_ptr_inc;
                    if (out_last_q) begin
                        state_d     = S_CAPTURE;
                        out_valid_d = 1'b0;
                        out_last_d  = 1'b0;
                        occ_d       = '0;
                        wrapped_d   = 1'b0;
                    end else begin
                        // Read ahead from the incremented pointer so the next beat has no bubble.
                        occ_d      = occ_q - OCC_ONE;
                        out_last_d = (occ_q == OCC_TWO);
                        vec_d      = mem[rd_ptr_inc];
                    end
                end
            end

            default: begin
                state_d = S_CAPTURE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_CAPTURE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            occ_q       <= '0;
            wrapped_q   <= 1'b0;
            drop_q      <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            vec_q       <= '0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            occ_q       <= occ_d;
            wrapped_q   <= wrapped_d;
            drop_q      <= drop_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            vec_q       <= vec_d;
        end
    end

    // Storage is deliberately unreset so it can map onto a simple dual-port RAM.
    always_ff @(posedge clk) begin
        if (write_en) begin
            mem[wr_ptr_q] <= vector_in;
        end
    end

    assign out_valid   = out_valid_q;
    assign vector_out  = vec_q;
    assign out_last    = out_last_q;
    assign occupancy   = occ_q;
    assign wrapped     = wrapped_q;
    assign drop_count  = drop_q;
    assign busy        = (state_q == S_DRAIN);
    assign dbg_state_o = state_q;

endmodule
